// File: rtl/display_scheduler.sv
// display_scheduler: arbitrates number updates and error reports for the 4-digit display.
// Optional error blinking is built when DISPLAY_SCHEDULER_BLINK_EN is defined.
module display_scheduler #(
  parameter int unsigned HOLD_CYCLES  = 50_000_000,
  parameter int unsigned MIN_CYCLES   = 5_000_000,
  parameter int unsigned BLINK_CYCLES = 12_500_000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        num_valid,
  input  logic [15:0] num_data,
  input  logic        num_overflow,
  output logic        num_ready,
  input  logic        err_valid,
  input  logic [3:0]  err_code,
  output logic        err_ready,
  input  logic        clear,
  output logic [15:0] number,
  output logic        overflow,
  output logic [3:0]  error,
  output logic        error_active
);

  typedef enum logic {
    SHOW_NUMBER = 1'b0,
    SHOW_ERROR  = 1'b1
  } state_e;

  localparam logic [31:0] HoldLoad = 32'(HOLD_CYCLES);
  localparam logic [31:0] MinLoad  = 32'(MIN_CYCLES);

  state_e      state_q, state_d;
  logic [31:0] min_cnt_q, min_cnt_d;
  logic [31:0] hold_cnt_q, hold_cnt_d;
  logic [15:0] number_q, number_d;
  logic        overflow_q, overflow_d;
  logic [3:0]  code_q, code_d;
  logic        show_code;

  logic num_accept;
  logic err_set;
  logic err_clear;
  logic hold_expire;

  assign num_ready   = (min_cnt_q == '0);
  assign err_ready   = 1'b1;
  assign num_accept  = num_valid && num_ready;
  assign err_set     = err_valid && (err_code != 4'h0);
  assign err_clear   = (err_valid && (err_code == 4'h0)) || clear;
  // A sticky error (HOLD_CYCLES == 0) never loads the counter, so it never expires.
  assign hold_expire = (hold_cnt_q == 32'd1);

  always_comb begin
    number_d   = number_q;
    overflow_d = overflow_q;
    min_cnt_d  = min_cnt_q;
    if (num_accept) begin
      number_d   = num_data;
      overflow_d = num_overflow;
      min_cnt_d  = MinLoad;
    end else if (min_cnt_q != '0) begin
      min_cnt_d = min_cnt_q - 32'd1;
    end
  end

  // A nonzero error always wins over clear or hold expiry in the same cycle.
  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    hold_cnt_d = hold_cnt_q;
    if (state_q == SHOW_ERROR && hold_cnt_q != '0) begin
      hold_cnt_d = hold_cnt_q - 32'd1;
    end
    if (err_set) begin
      state_d    = SHOW_ERROR;
      code_d     = err_code;
      hold_cnt_d = HoldLoad;
    end else if (state_q == SHOW_ERROR && (err_clear || hold_expire)) begin
      state_d    = SHOW_NUMBER;
      hold_cnt_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= SHOW_NUMBER;
      min_cnt_q  <= '0;
      hold_cnt_q <= '0;
      number_q   <= '0;
      overflow_q <= 1'b0;
      code_q     <= '0;
    end else begin
      state_q    <= state_d;
      min_cnt_q  <= min_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      number_q   <= number_d;
      overflow_q <= overflow_d;
      code_q     <= code_d;
    end
  end

`ifdef DISPLAY_SCHEDULER_BLINK_EN
  localparam logic [31:0] BlinkLoad = 32'(BLINK_CYCLES);

  logic [31:0] blink_cnt_q, blink_cnt_d;
  logic        phase_q, phase_d;

  // Phase restarts on the code at every error accept; BLINK_CYCLES == 0 shows it steadily.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (err_set) begin
      blink_cnt_d = BlinkLoad;
      phase_d     = 1'b1;
    end else if (state_q == SHOW_ERROR) begin
      if (blink_cnt_q == 32'd1) begin
        blink_cnt_d = BlinkLoad;
        phase_d     = ~phase_q;
      end else if (blink_cnt_q != '0) begin
        blink_cnt_d = blink_cnt_q - 32'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  assign show_code = phase_q;
`else
  assign show_code = 1'b1;
`endif

  assign number       = number_q;
  assign overflow     = overflow_q;
  assign error        = (state_q == SHOW_ERROR && show_code) ? code_q : 4'h0;
  assign error_active = (state_q == SHOW_ERROR);

endmodule
